// File: rtl/ingress_rr_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler: grants one ingress buffer holding a complete frame, streams it out as AXI-Stream
// and pulses that buffer's flush. Define SCHED_STATS_EN to add the pkt_count/byte_count outputs.
module ingress_rr_scheduler #(
  parameter int N_PORTS        = 4,
  parameter int FIFO_ADDR_SIZE = 10
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [N_PORTS-1:0]                  port_ready,
  input  logic [N_PORTS*FIFO_ADDR_SIZE-1:0]   port_data_len,
  input  logic [N_PORTS*32-1:0]               port_data,
  output logic [FIFO_ADDR_SIZE-1:0]           read_ptr,
  output logic [N_PORTS-1:0]                  port_flush,
  output logic [31:0]                         m_axis_tdata,
  output logic [3:0]                          m_axis_tkeep,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [$clog2(N_PORTS)-1:0]          grant_port,
  output logic                                busy
`ifdef SCHED_STATS_EN
 ,output logic [31:0]                         pkt_count,
  output logic [31:0]                         byte_count
`endif
);

  localparam int GW = $clog2(N_PORTS);
  localparam int AW = FIFO_ADDR_SIZE;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  localparam logic [AW:0] BEAT_BYTES = (AW+1)'(4);

  logic [1:0]         r_state;
  logic [GW-1:0]      r_grant;
  logic [AW-1:0]      r_len;
  logic [AW-1:0]      r_read_ptr;
  logic [N_PORTS-1:0] r_flush;
  logic [31:0]        r_tdata;
  logic [3:0]         r_tkeep;
  logic               r_tvalid;
  logic               r_tlast;

  logic [GW-1:0]      w_next_grant;
  logic               w_any_ready;
  logic [AW-1:0]      w_grant_len;
  logic [31:0]        w_grant_word;
  logic [N_PORTS-1:0] w_grant_onehot;
  logic [AW:0]        w_rem;
  logic [AW:0]        w_ptr_sum;
  logic [AW-1:0]      w_ptr_next;
  logic [3:0]         w_keep;
  logic               w_load;
  logic               w_last_accept;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    w_next_grant = r_grant;
    w_any_ready  = 1'b0;
    // Walk from the farthest candidate back to grant+1 so the nearest ready port is written last.
    for (int i = N_PORTS; i >= 1; i--) begin
      if (port_ready[(int'(r_grant) + i) % N_PORTS]) begin
        w_next_grant = GW'((int'(r_grant) + i) % N_PORTS);
        w_any_ready  = 1'b1;
      end
    end
  end

  assign w_grant_len    = port_data_len[int'(r_grant)*AW +: AW];
  assign w_grant_word   = port_data[int'(r_grant)*32 +: 32];
  assign w_grant_onehot = {{(N_PORTS-1){1'b0}}, 1'b1} << r_grant;

  assign w_rem      = {1'b0, r_len} - {1'b0, r_read_ptr};
  assign w_ptr_sum  = {1'b0, r_read_ptr} + BEAT_BYTES;
  assign w_ptr_next = w_ptr_sum[AW] ? {AW{1'b1}} : w_ptr_sum[AW-1:0];

  always_comb begin
    w_keep = 4'hF;
    if (w_rem < BEAT_BYTES) begin
      case (w_rem[1:0])
        2'd1:    w_keep = 4'b0001;
        2'd2:    w_keep = 4'b0011;
        2'd3:    w_keep = 4'b0111;
        default: w_keep = 4'b0000;
      endcase
    end
  end

  assign w_last_accept = r_tvalid && m_axis_tready && r_tlast;
  // Once the tlast beat sits in the output register nothing more is fetched for this frame.
  assign w_load = (r_state == S_STREAM) && (!r_tvalid || m_axis_tready) && !(r_tvalid && r_tlast);

  // NOTE: sequential state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_grant    <= GW'(N_PORTS - 1);
      r_len      <= '0;
      r_read_ptr <= '0;
      r_flush    <= '0;
      r_tdata    <= '0;
      r_tkeep    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
    end else begin
      r_flush <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_ready) begin
            r_grant <= w_next_grant;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_len      <= w_grant_len;
          r_read_ptr <= '0;
          if (w_grant_len == '0) begin
            r_flush <= w_grant_onehot;
            r_state <= S_FLUSH;
          end else begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_last_accept) begin
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_read_ptr <= '0;
            r_flush    <= w_grant_onehot;
            r_state    <= S_FLUSH;
          end else if (w_load) begin
            r_tdata    <= {w_grant_word[7:0], w_grant_word[15:8], w_grant_word[23:16], w_grant_word[31:24]};
            r_tkeep    <= w_keep;
            r_tlast    <= (w_rem <= BEAT_BYTES);
            r_tvalid   <= 1'b1;
            r_read_ptr <= w_ptr_next;
          end
        end
        S_FLUSH: begin
          r_read_ptr <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_byte_count;
  logic        w_flush_entry;
  logic [31:0] w_flush_bytes;

  // A zero-length frame enters FLUSH straight from GRANT and contributes no bytes.
  assign w_flush_entry = ((r_state == S_GRANT) && (w_grant_len == '0)) ||
                         ((r_state == S_STREAM) && w_last_accept);
  assign w_flush_bytes = (r_state == S_STREAM) ? 32'(r_len) : 32'd0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_count  <= '0;
      r_byte_count <= '0;
    end else if (w_flush_entry) begin
      r_pkt_count  <= r_pkt_count + 32'd1;
      r_byte_count <= r_byte_count + w_flush_bytes;
    end
  end

  assign pkt_count  = r_pkt_count;
  assign byte_count = r_byte_count;
`endif

  assign read_ptr      = r_read_ptr;
  assign port_flush    = r_flush;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign grant_port    = r_grant;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_ingress_rr_scheduler.sv
`timescale 1ns/1ps
// Bench for ingress_rr_scheduler: byte-array buffer models, a round-robin order model and a beat scoreboard.
module tb_ingress_rr_scheduler;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int MEM_BYTES = 256;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  gnt;
  } beat_t;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    port_ready;
  logic [N*AW-1:0] port_data_len;
  logic [N*32-1:0] port_data;
  logic [AW-1:0]   read_ptr;
  logic [N-1:0]    port_flush;
  logic [31:0]     m_axis_tdata;
  logic [3:0]      m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready;
  logic [1:0]      grant_port;
  logic            busy;
`ifdef SCHED_STATS_EN
  logic [31:0]     pkt_count;
  logic [31:0]     byte_count;
`endif

  ingress_rr_scheduler #(.N_PORTS(N), .FIFO_ADDR_SIZE(AW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .port_ready    (port_ready),
    .port_data_len (port_data_len),
    .port_data     (port_data),
    .read_ptr      (read_ptr),
    .port_flush    (port_flush),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant_port    (grant_port),
    .busy          (busy)
`ifdef SCHED_STATS_EN
   ,.pkt_count     (pkt_count),
    .byte_count    (byte_count)
`endif
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  // Buffer models: a frame is present while more frames were loaded than flushed.
  logic [7:0]  mem [N][MEM_BYTES];
  int          frame_len [N];
  int unsigned load_cnt [N];
  int unsigned flush_cnt [N];

  always_comb begin
    port_ready    = '0;
    port_data_len = '0;
    port_data     = '0;
    for (int i = 0; i < N; i++) begin
      port_ready[i]             = (load_cnt[i] != flush_cnt[i]);
      port_data_len[i*AW +: AW] = AW'(frame_len[i]);
      for (int b = 0; b < 4; b++)
        if (int'(read_ptr) + b < frame_len[i])
          port_data[i*32 + (3-b)*8 +: 8] = mem[i][int'(read_ptr) + b];
    end
  end

  always @(posedge aclk)
    for (int i = 0; i < N; i++)
      if (port_flush[i]) flush_cnt[i] <= flush_cnt[i] + 1;

  // Sink back-pressure: random stalls plus a hard block the scenarios can raise.
  int   stall_pct = 0;
  logic tready_gen = 1'b1;
  logic tb_block = 1'b0;
  always @(negedge aclk) tready_gen = (int'($urandom_range(99)) >= stall_pct);
  assign m_axis_tready = tready_gen && !tb_block;

  // Scoreboard: expected beats and flush pulses, queued in the order frames must be served.
  beat_t        exp_beat_q[$];
  logic [N-1:0] exp_flush_q[$];
  beat_t        mon_got;
  beat_t        mon_want;
  logic [N-1:0] mon_flush_want;

  always begin
    @(negedge aclk);
    #2;
    if (aresetn) begin
      if (m_axis_tvalid && m_axis_tready) begin
        mon_got = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, grant_port};
        vectors++;
        if (exp_beat_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got data=%h keep=%h last=%0d port=%0d, want no beat",
                   mon_got.data, mon_got.keep, mon_got.last, mon_got.gnt);
        end else begin
          mon_want = exp_beat_q.pop_front();
          if (mon_got !== mon_want) begin
            miscompares++;
            $display("FAIL beat: got data=%h keep=%h last=%0d port=%0d, want data=%h keep=%h last=%0d port=%0d",
                     mon_got.data, mon_got.keep, mon_got.last, mon_got.gnt,
                     mon_want.data, mon_want.keep, mon_want.last, mon_want.gnt);
          end
        end
      end
      if (port_flush != '0) begin
        vectors++;
        mon_flush_want = (exp_flush_q.size() == 0) ? '0 : exp_flush_q.pop_front();
        if (port_flush !== mon_flush_want) begin
          miscompares++;
          $display("FAIL flush: got %b want %b", port_flush, mon_flush_want);
        end
      end
    end
  end

  int model_last = N - 1;

  function automatic int rr_pick(input logic [N-1:0] set);
    for (int i = 1; i <= N; i++)
      if (set[(model_last + i) % N]) return (model_last + i) % N;
    return -1;
  endfunction

  // Expected beats: bytes in frame order, 4 per beat, byte 0 in tdata[7:0], keep covers the valid bytes.
  task automatic push_frame(input int p);
    int    len;
    int    nb;
    int    rem;
    beat_t b;
    len = frame_len[p];
    nb  = (len + 3) / 4;
    for (int k = 0; k < nb; k++) begin
      rem    = len - 4*k;
      b.keep = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
      for (int j = 0; j < 4; j++)
        b.data[8*j +: 8] = (4*k + j < len) ? mem[p][4*k + j] : 8'h00;
      b.last = (k == nb - 1);
      b.gnt  = 2'(p);
      exp_beat_q.push_back(b);
    end
    exp_flush_q.push_back(N'(1 << p));
    model_last = p;
  endtask

  // NOTE: stimulus is driven with blocking assignments at the falling edge, clear of the DUT's sampling edge.
  task automatic load_frame(input int p, input int len, input bit rnd);
    frame_len[p] = len;
    for (int b = 0; b < len; b++) mem[p][b] = rnd ? 8'($urandom) : 8'(b + 1);
    load_cnt[p]++;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge aclk);
      if (exp_beat_q.size() == 0 && exp_flush_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    exp_beat_q.delete();
    exp_flush_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    model_last = N - 1;
  endtask

  task automatic test_reset();
    logic [31:0] got [8];
    logic [31:0] want [8];
    string       nm [8];
    repeat (2) @(negedge aclk);
    got  = '{32'(read_ptr), 32'(port_flush), 32'(m_axis_tvalid), 32'(m_axis_tlast),
             m_axis_tdata, 32'(m_axis_tkeep), 32'(grant_port), 32'(busy)};
    want = '{0, 0, 0, 0, 0, 0, N - 1, 0};
    nm   = '{"read_ptr", "port_flush", "tvalid", "tlast", "tdata", "tkeep", "grant_port", "busy"};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL reset_%s: got %0h want %0h", nm[i], got[i], want[i]);
      end
    end
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_single_frame();
    bit ok;
    stall_pct = 0;
    @(negedge aclk);
    load_frame(1, 6, 1'b0);
    push_frame(rr_pick(4'b0010));
    @(negedge aclk);
    vectors++;
    if ({busy, m_axis_tvalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_grant_cycle: got busy/tvalid=%b want 10", {busy, m_axis_tvalid});
    end
    @(negedge aclk);
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early_tvalid: got %b want 0", m_axis_tvalid);
    end
    @(negedge aclk);
    vectors++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, 32'h04030201, 4'hF, 1'b0}) begin
      miscompares++;
      $display("FAIL single_first_beat: got valid=%b data=%h keep=%h last=%b want 1 04030201 f 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    wait_done(200, ok);
    vectors++;
    if (!ok || grant_port !== 2'd1) begin
      miscompares++;
      $display("FAIL single_done: got done=%0d grant=%0d want done=1 grant=1", ok, grant_port);
    end
  endtask

  task automatic test_rr_order();
    bit ok;
    int budget;
    do_reset();
    stall_pct = 30;
    @(negedge aclk);
    load_frame(0, $urandom_range(1, 20), 1'b1);
    load_frame(2, $urandom_range(1, 20), 1'b1);
    push_frame(rr_pick(4'b0101));
    push_frame(rr_pick(4'b0100));
    budget = 0;
    while (flush_cnt[0] != load_cnt[0] && budget < 300) begin
      @(negedge aclk);
      budget++;
    end
    load_frame(0, $urandom_range(1, 20), 1'b1);
    push_frame(rr_pick(4'b0001));
    wait_done(1000, ok);
    vectors++;
    if (!ok || grant_port !== 2'd0) begin
      miscompares++;
      $display("FAIL rr_order_done: got done=%0d grant=%0d want done=1 grant=0", ok, grant_port);
    end
  endtask

  task automatic test_backpressure();
    bit          ok;
    logic [31:0] want_data;
    stall_pct = 0;
    tb_block  = 1'b1;
    @(negedge aclk);
    load_frame(2, 8, 1'b1);
    push_frame(rr_pick(4'b0100));
    want_data = {mem[2][3], mem[2][2], mem[2][1], mem[2][0]};
    for (int c = 0; c < 10 && !m_axis_tvalid; c++) @(negedge aclk);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, read_ptr} !==
          {1'b1, want_data, 4'hF, 1'b0, AW'(4)}) begin
        miscompares++;
        $display("FAIL stall_hold: got valid=%b data=%h keep=%h last=%b ptr=%0d want 1 %h f 0 4",
                 m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, read_ptr, want_data);
      end
      @(negedge aclk);
    end
    tb_block = 1'b0;
    wait_done(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL stall_done: got timeout want frame complete");
    end
  endtask

  task automatic test_zero_len();
    bit           ok;
    logic [N+1:0] got [3];
    logic [N+1:0] want [3];
    @(negedge aclk);
    load_frame(3, 0, 1'b0);
    push_frame(rr_pick(4'b1000));
    want = '{{1'b1, 1'b0, 4'b0000}, {1'b1, 1'b0, 4'b1000}, {1'b0, 1'b0, 4'b0000}};
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      got[c] = {busy, m_axis_tvalid, port_flush};
      vectors++;
      if (got[c] !== want[c]) begin
        miscompares++;
        $display("FAIL zero_len_cycle%0d: got busy/tvalid/flush=%b want %b", c + 1, got[c], want[c]);
      end
    end
    wait_done(50, ok);
    vectors++;
    if (!ok || grant_port !== 2'd3) begin
      miscompares++;
      $display("FAIL zero_len_done: got done=%0d grant=%0d want done=1 grant=3", ok, grant_port);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit          ok;
    logic [54:0] got;
    stall_pct = 0;
    @(negedge aclk);
    load_frame(1, 12, 1'b1);
    push_frame(rr_pick(4'b0010));
    for (int c = 0; c < 20 && exp_beat_q.size() > 2; c++) @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    got = {read_ptr, port_flush, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, grant_port, busy};
    vectors++;
    if (got !== {10'd0, 4'd0, 1'b0, 1'b0, 32'd0, 4'd0, 2'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h want %h", got, {10'd0, 4'd0, 1'b0, 1'b0, 32'd0, 4'd0, 2'd3, 1'b0});
    end
    exp_beat_q.delete();
    exp_flush_q.delete();
    @(negedge aclk);
    vectors++;
    if (port_ready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_no_flush: got ready1=%b want 1", port_ready[1]);
    end
    aresetn = 1'b1;
    model_last = N - 1;
    push_frame(rr_pick(4'b0010));
    wait_done(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midreset_resend: got timeout want whole frame");
    end
  endtask

  task automatic test_random();
    bit           ok;
    logic [N-1:0] set;
    int           p;
    do_reset();
    for (int r = 0; r < 20; r++) begin
      stall_pct = $urandom_range(0, 50);
      @(negedge aclk);
      set = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++)
        if (set[i]) load_frame(i, $urandom_range(0, 40), 1'b1);
      while (set != '0) begin
        p = rr_pick(set);
        push_frame(p);
        set[p] = 1'b0;
      end
      wait_done(2000, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL random_round%0d: got timeout want all frames served", r);
      end
    end
  endtask

`ifdef SCHED_STATS_EN
  task automatic test_stats();
    bit ok;
    int lens [3] = '{6, 0, 64};
    do_reset();
    stall_pct = 20;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      load_frame(i, lens[i], 1'b1);
      push_frame(rr_pick(N'(1 << i)));
      wait_done(500, ok);
    end
    vectors++;
    if ({pkt_count, byte_count} !== {32'd3, 32'd70}) begin
      miscompares++;
      $display("FAIL stats: got pkt=%0d bytes=%0d want pkt=3 bytes=70", pkt_count, byte_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_rr_order();
    test_backpressure();
    test_zero_len();
    test_reset_mid_frame();
    test_random();
`ifdef SCHED_STATS_EN
    test_stats();
`endif
    repeat (3) @(negedge aclk);
    vectors++;
    if (exp_beat_q.size() != 0 || exp_flush_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d beats %0d flushes outstanding want 0 0", exp_beat_q.size(), exp_flush_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
